// File: rtl/fix2_flo_conv_pipe_if.sv
// Sample stream bundle for the fixed-to-float converter: input side
// (data_in/valid_in/ready_out) and output side (data_out/valid_out/last/ready_in).
interface fix2_flo_conv_pipe_if;
  logic [31:0] data_in;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] data_out;
  logic        valid_out;
  logic        last;
  logic        ready_in;

  // Converter side
  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out, last
  );

  // Producer/consumer side
  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out, last
  );
endinterface

// File: rtl/fix2_flo_conv_pipe.sv
// Fixed-point sample to IEEE-754 single converter: capture, leading-one detect,
// normalise/exponent, output register, with a global stall and a frame counter.
module fix2_flo_conv_pipe #(
  parameter int IN_W    = 12,
  parameter int SCALE_W = 4,
  parameter int FRM_W   = 8
) (
  input  logic               hclk,
  input  logic               rst,
  fix2_flo_conv_pipe_if.slave bus,
  input  logic               signed_mode,
  input  logic [SCALE_W-1:0] scale,
  input  logic [FRM_W-1:0]   frame_len
);

  localparam int POS_W = 5;
  localparam int EXP_W = 8;
  localparam logic [EXP_W-1:0] BIAS = 8'd127;

  logic en;

  // S1 capture
  logic [IN_W-1:0]    s1_x;
  logic               s1_neg;
  logic [IN_W-1:0]    s1_mag_d;
  logic               s1_valid;
  logic               s1_sign;
  logic [IN_W-1:0]    s1_mag;
  logic [SCALE_W-1:0] s1_scale;

  // S2 leading-one detect
  logic [POS_W-1:0]   lod_pos;
  logic               s2_valid;
  logic               s2_sign;
  logic               s2_zero;
  logic [IN_W-1:0]    s2_mag;
  logic [POS_W-1:0]   s2_pos;
  logic [SCALE_W-1:0] s2_scale;

  // S3 normalise
  logic [23:0]        norm;
  logic [EXP_W-1:0]   exp_d;
  logic               s3_valid;
  logic               s3_sign;
  logic               s3_zero;
  logic [EXP_W-1:0]   s3_exp;
  logic [22:0]        s3_mant;

  logic [FRM_W-1:0]   cnt;
  logic               out_hs;

  // One stall signal for the whole pipe keeps ordering trivially intact.
  assign en            = !bus.valid_out || bus.ready_in;
  assign bus.ready_out = en && !rst;
  assign out_hs        = bus.valid_out && bus.ready_in;
  assign bus.last      = bus.valid_out && (cnt == frame_len - FRM_W'(1));

  assign s1_x     = bus.data_in[IN_W-1:0];
  assign s1_neg   = signed_mode & s1_x[IN_W-1];
  assign s1_mag_d = s1_neg ? (~s1_x + IN_W'(1)) : s1_x;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lod_pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag[i]) lod_pos = POS_W'(i);
    end
  end

  // Shift the leading one up to bit 23; bits below it form the exact mantissa.
  assign norm  = 24'(s2_mag) << (POS_W'(23) - s2_pos);
  assign exp_d = BIAS + EXP_W'(s2_pos) + EXP_W'(s2_scale);

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      s3_valid      <= 1'b0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= '0;
    end else if (en) begin
      s1_valid      <= bus.valid_in;
      s2_valid      <= s1_valid;
      s3_valid      <= s2_valid;
      bus.valid_out <= s3_valid;
      bus.data_out  <= s3_zero ? 32'h0 : {s3_sign, s3_exp, s3_mant};
    end
  end

  // NOTE: datapath registers carry no reset; their contents are qualified by the stage valids.
  always_ff @(posedge hclk) begin
    if (en) begin
      s1_sign  <= s1_neg;
      s1_mag   <= s1_mag_d;
      s1_scale <= scale;

      s2_sign  <= s1_sign;
      s2_zero  <= (s1_mag == '0);
      s2_mag   <= s1_mag;
      s2_pos   <= lod_pos;
      s2_scale <= s1_scale;

      s3_sign  <= s2_sign;
      s3_zero  <= s2_zero;
      s3_exp   <= exp_d;
      s3_mant  <= norm[22:0];
    end
  end

  // Frame position of the beat currently on data_out.
  always_ff @(posedge hclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (out_hs) begin
      cnt <= bus.last ? '0 : cnt + FRM_W'(1);
    end
  end

endmodule

// File: tb/tb_fix2_flo_conv_pipe.sv
// Directed bench for fix2_flo_conv_pipe: latency, conversion vectors, backpressure,
// frame marking, stall on a last beat and reset mid-frame.
module tb_fix2_flo_conv_pipe;

  logic       hclk = 1'b0;
  logic       rst;
  logic       signed_mode;
  logic [3:0] scale;
  logic [7:0] frame_len;

  fix2_flo_conv_pipe_if tb_if ();

  fix2_flo_conv_pipe #(
    .IN_W   (12),
    .SCALE_W(4),
    .FRM_W  (8)
  ) dut (
    .hclk       (hclk),
    .rst        (rst),
    .bus        (tb_if),
    .signed_mode(signed_mode),
    .scale      (scale),
    .frame_len  (frame_len)
  );

  always #5 hclk = ~hclk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_last   = 0;
  int          n_out    = 0;
  int          frame_pos = 0;
  bit          rand_rdy = 1'b0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Independent reference for exact integers: narrow the double encoding.
  function automatic logic [31:0] to_f32(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    if (r == 0.0) return 32'h0;
    e = int'(d[62:52]) - 896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
    if (rand_rdy) tb_if.ready_in = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] x, input logic sm, input logic [3:0] sc,
                      input logic [31:0] exp);
    logic acc;
    int   budget;
    budget = 0;
    tb_if.data_in  = x;
    tb_if.valid_in = 1'b1;
    signed_mode    = sm;
    scale          = sc;
    do begin
      @(negedge hclk);
      acc = tb_if.ready_out;
      tick();
      budget++;
    end while (!acc && budget < 200);
    check("send_accept", 32'(acc), 1);
    if (acc) exp_q.push_back(exp);
  endtask

  task automatic idle();
    tb_if.valid_in = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      tick();
      budget++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset();
    @(posedge hclk);
    #1;
    rst            = 1'b1;
    tb_if.valid_in = 1'b0;
    tb_if.ready_in = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    rst = 1'b0;
  endtask

  task automatic lat(input logic [31:0] x, input logic [31:0] exp);
    int edges;
    send(x, 1'b1, 4'd0, exp);
    idle();
    edges = 0;
    do begin
      @(posedge hclk);
      #1;
      edges++;
    end while (!tb_if.valid_out && edges < 10);
    check("latency", 32'(edges), 3);
    drain();
  endtask

  // Output scoreboard; the handshake seen at a falling edge completes on the next rising edge.
  task automatic monitor();
    logic [31:0] e;
    logic        exp_last;
    int          flen;
    forever begin
      @(negedge hclk);
      if (rst) begin
        frame_pos = 0;
        exp_q.delete();
      end else begin
        check("ready_out", 32'(tb_if.ready_out), 32'(!(tb_if.valid_out && !tb_if.ready_in)));
        if (!tb_if.valid_out) check("last_idle", 32'(tb_if.last), 0);
        if (tb_if.valid_out && tb_if.ready_in) begin
          check("out_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data_out", tb_if.data_out, e);
            flen     = (frame_len == 0) ? 256 : int'(frame_len);
            exp_last = (frame_pos + 1 == flen);
            check("last", 32'(tb_if.last), 32'(exp_last));
            frame_pos = exp_last ? 0 : frame_pos + 1;
          end
          if (tb_if.last) n_last++;
          n_out++;
        end
      end
    end
  endtask

  initial begin
    int base;
    rst            = 1'b1;
    tb_if.data_in  = '0;
    tb_if.valid_in = 1'b0;
    tb_if.ready_in = 1'b1;
    signed_mode    = 1'b1;
    scale          = '0;
    frame_len      = 8'd0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge hclk);
    #1;
    check("rst_ready_out", 32'(tb_if.ready_out), 0);
    check("rst_valid_out", 32'(tb_if.valid_out), 0);
    check("rst_last", 32'(tb_if.last), 0);
    check("rst_data_out", tb_if.data_out, 0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(tb_if.ready_out), 1);

    // 1: signed, scale 0, three-edge latency
    lat(32'h000, 32'h00000000);
    lat(32'h001, 32'h3F800000);
    lat(32'hFFF, 32'hBF800000);
    lat(32'h800, 32'hC5000000);

    // 2: scale and mode changes on back-to-back samples; upper input bits ignored
    send(32'h7FF,       1'b1, 4'd4,  32'h46FFE000);
    send(32'h0000_0FFF, 1'b0, 4'd0,  32'h457FF000);
    send(32'hABCD_0000, 1'b1, 4'd15, 32'h00000000);
    send(32'hFFFF_F000, 1'b0, 4'd0,  32'h00000000);
    idle();
    drain();

    // 3: random backpressure, ordered and lossless
    base     = n_out;
    rand_rdy = 1'b1;
    for (int i = 0; i < 20; i++) send(32'(i), 1'b1, 4'd0, to_f32(real'(i)));
    idle();
    drain();
    rand_rdy       = 1'b0;
    tb_if.ready_in = 1'b1;
    check("bp_out_count", 32'(n_out - base), 20);

    // 4: frame_len = 4, then frame_len = 0 (256)
    frame_len = 8'd4;
    do_reset();
    base = n_last;
    for (int i = 1; i <= 10; i++) send(32'(i), 1'b1, 4'd0, to_f32(real'(i)));
    idle();
    drain();
    check("f4_last_10", 32'(n_last - base), 2);
    for (int i = 11; i <= 12; i++) send(32'(i), 1'b1, 4'd0, to_f32(real'(i)));
    idle();
    drain();
    check("f4_last_12", 32'(n_last - base), 3);

    frame_len = 8'd0;
    do_reset();
    base = n_last;
    for (int i = 0; i < 256; i++) send(32'(i), 1'b0, 4'd0, to_f32(real'(i)));
    idle();
    drain();
    check("f256_last", 32'(n_last - base), 1);

    // 5: stall on a last beat
    frame_len = 8'd2;
    do_reset();
    send(32'd5, 1'b1, 4'd0, to_f32(5.0));
    idle();
    drain();
    tb_if.ready_in = 1'b0;
    send(32'd7, 1'b1, 4'd0, 32'h40E00000);
    idle();
    for (int i = 0; i < 10 && !tb_if.valid_out; i++) tick();
    check("stall_valid", 32'(tb_if.valid_out), 1);
    check("stall_last", 32'(tb_if.last), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_hold_data", tb_if.data_out, 32'h40E00000);
      check("stall_hold_last", 32'(tb_if.last), 1);
    end
    tb_if.ready_in = 1'b1;
    drain();
    base = n_last;
    send(32'd9, 1'b1, 4'd0, to_f32(9.0));
    send(32'd10, 1'b1, 4'd0, to_f32(10.0));
    idle();
    drain();
    check("after_stall_last", 32'(n_last - base), 1);

    // 6: reset mid-frame with three samples in flight
    frame_len = 8'd3;
    do_reset();
    for (int i = 1; i <= 6; i++) send(32'(i), 1'b1, 4'd0, to_f32(real'(i)));
    check("pre_rst_valid", 32'(tb_if.valid_out), 1);
    check("pre_rst_last", 32'(tb_if.last), 1);
    rst            = 1'b1;
    tb_if.valid_in = 1'b0;
    #1;
    check("rst_drop_valid", 32'(tb_if.valid_out), 0);
    check("rst_drop_last", 32'(tb_if.last), 0);
    check("rst_drop_ready", 32'(tb_if.ready_out), 0);
    repeat (2) @(posedge hclk);
    #1;
    rst  = 1'b0;
    base = n_last;
    for (int i = 0; i < 2; i++) send(32'(i + 20), 1'b1, 4'd0, to_f32(real'(i + 20)));
    idle();
    drain();
    check("rst_no_early_last", 32'(n_last - base), 0);
    send(32'd30, 1'b1, 4'd0, to_f32(30.0));
    idle();
    drain();
    check("rst_frame_last", 32'(n_last - base), 1);

    repeat (3) @(posedge hclk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
